// File: rtl/recovery_supervisor.sv
// Recovery supervisor: sequences the clock event-recovery datapath through
// settle, acquisition and lock, watches lock continuously, retries failed
// acquisitions (optionally flipping polarity) and raises a sticky fault.

package common_p;
    // Clock/reset bundle for one clock domain; rst_n is asynchronous, active-low.
    typedef struct packed {
        logic clk;
        logic rst_n;
    } clk_dom;
endpackage

package clks_alot_p;
    // Operating modes understood by the event-recovery datapath.
    typedef enum logic [1:0] {
        REC_MODE_EDGE       = 2'd0,
        REC_MODE_PULSE      = 2'd1,
        REC_MODE_MANCHESTER = 2'd2,
        REC_MODE_BIPHASE    = 2'd3
    } recovery_mode_e;
endpackage

module recovery_supervisor #(
    parameter int CNT_W         = 16,
    parameter int LOCK_EDGES    = 8,
    parameter int SETTLE_CYCLES = 4,
    parameter int RETRY_LIMIT   = 3
) (
    input  common_p::clk_dom            sys_dom_i,
    input  logic                        start_i,
    input  logic                        stop_i,
    input  clks_alot_p::recovery_mode_e cfg_mode_i,
    input  logic                        cfg_polarity_i,
    input  logic                        auto_flip_i,
    input  logic                        check_secondary_i,
    input  logic [CNT_W-1:0]            timeout_i,
    input  logic                        primary_edge_i,
    input  logic                        secondary_edge_i,
    output logic                        recovery_en_o,
    output logic                        polarity_select_o,
    output clks_alot_p::recovery_mode_e recovery_mode_o,
    output logic                        locked_o,
    output logic                        lost_o,
    output logic                        fault_o,
    output logic [CNT_W-1:0]            period_o,
    output logic [3:0]                  retries_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_ACQUIRE,
        ST_LOCKED,
        ST_FAULT
    } state_e;

    localparam int                SET_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [7:0]        LOCK_LAST   = 8'(LOCK_EDGES - 1);
    localparam logic [3:0]        RETRY_MAX   = 4'(RETRY_LIMIT);
    localparam logic [CNT_W-1:0]  GAP_MAX     = '1;

    logic w_clk;
    logic w_rst_n;
    assign w_clk   = sys_dom_i.clk;
    assign w_rst_n = sys_dom_i.rst_n;

    // Registered state and outputs
    state_e                      r_state;
    logic [CNT_W-1:0]            r_gap;
    logic [SET_W-1:0]            r_settle_cnt;
    logic [7:0]                  r_valid_cnt;
    logic                        r_armed;
    logic                        r_sec_seen;
    logic                        r_recovery_en;
    logic                        r_polarity;
    clks_alot_p::recovery_mode_e r_mode;
    logic                        r_locked;
    logic                        r_lost;
    logic                        r_fault;
    logic [CNT_W-1:0]            r_period;
    logic [3:0]                  r_retries;

    // Next-state values
    state_e                      w_state_nxt;
    logic [CNT_W-1:0]            w_gap_nxt;
    logic [SET_W-1:0]            w_settle_cnt_nxt;
    logic [7:0]                  w_valid_cnt_nxt;
    logic                        w_armed_nxt;
    logic                        w_sec_seen_nxt;
    logic                        w_recovery_en_nxt;
    logic                        w_polarity_nxt;
    clks_alot_p::recovery_mode_e w_mode_nxt;
    logic                        w_locked_nxt;
    logic                        w_lost_nxt;
    logic                        w_fault_nxt;
    logic [CNT_W-1:0]            w_period_nxt;
    logic [3:0]                  w_retries_nxt;

    // Interval qualification. The interval ending at this cycle's primary edge
    // is gap + 1, computed one bit wider so a saturated gap cannot wrap.
    logic [CNT_W:0]   w_interval;
    logic [CNT_W-1:0] w_period_val;
    logic             w_interval_ok;
    logic             w_sec_ok;
    logic             w_edge_ok;
    logic             w_timeout_hit;
    logic             w_acq_fail;
    logic             w_violation;
    logic [3:0]       w_retries_inc;

    assign w_interval    = {1'b0, r_gap} + {{CNT_W{1'b0}}, 1'b1};
    assign w_period_val  = w_interval[CNT_W] ? GAP_MAX : w_interval[CNT_W-1:0];
    assign w_interval_ok = (timeout_i == '0) || (w_interval <= {1'b0, timeout_i});
    // A secondary edge coincident with the primary edge belongs to the closing interval.
    assign w_sec_ok      = !check_secondary_i || r_sec_seen || secondary_edge_i;
    assign w_edge_ok     = w_interval_ok && w_sec_ok;
    // When an edge is present it is judged by its interval, never by the timeout.
    assign w_timeout_hit = (timeout_i != '0) && (r_gap >= timeout_i) && !primary_edge_i;
    // The arming edge in ACQUIRE is never judged.
    assign w_acq_fail    = (primary_edge_i && r_armed && !w_edge_ok) || w_timeout_hit;
    assign w_violation   = (primary_edge_i && !w_edge_ok) || w_timeout_hit;
    assign w_retries_inc = r_retries + 4'd1;

    // Next-state and next-output logic for the supervisor FSM
    always_comb begin
        // NOTE: every target gets a hold/default value first, so no path can
        // leave a signal unassigned and infer a latch.
        w_state_nxt       = r_state;
        w_gap_nxt         = r_gap;
        w_settle_cnt_nxt  = r_settle_cnt;
        w_valid_cnt_nxt   = r_valid_cnt;
        w_armed_nxt       = r_armed;
        w_sec_seen_nxt    = r_sec_seen;
        w_recovery_en_nxt = r_recovery_en;
        w_polarity_nxt    = r_polarity;
        w_mode_nxt        = r_mode;
        w_locked_nxt      = r_locked;
        w_lost_nxt        = 1'b0;
        w_fault_nxt       = r_fault;
        w_period_nxt      = r_period;
        w_retries_nxt     = r_retries;

        // Gap counter and secondary flag run while measuring intervals.
        if (r_state == ST_ACQUIRE || r_state == ST_LOCKED) begin
            if (primary_edge_i) begin
                w_gap_nxt      = '0;
                w_sec_seen_nxt = 1'b0;
            end else begin
                w_gap_nxt      = (r_gap == GAP_MAX) ? r_gap : r_gap + 1'b1;
                w_sec_seen_nxt = r_sec_seen | secondary_edge_i;
            end
        end

        if (stop_i) begin
            w_state_nxt       = ST_IDLE;
            w_recovery_en_nxt = 1'b0;
            w_locked_nxt      = 1'b0;
            w_fault_nxt       = 1'b0;
            w_retries_nxt     = '0;
            w_gap_nxt         = '0;
            w_sec_seen_nxt    = 1'b0;
            w_valid_cnt_nxt   = '0;
            w_armed_nxt       = 1'b0;
            w_settle_cnt_nxt  = '0;
        end else if (start_i) begin
            w_state_nxt       = ST_SETTLE;
            w_mode_nxt        = cfg_mode_i;
            w_polarity_nxt    = cfg_polarity_i;
            w_recovery_en_nxt = 1'b1;
            w_locked_nxt      = 1'b0;
            w_fault_nxt       = 1'b0;
            w_retries_nxt     = '0;
            w_settle_cnt_nxt  = '0;
            w_gap_nxt         = '0;
            w_sec_seen_nxt    = 1'b0;
        end else begin
            case (r_state)
                ST_SETTLE: begin
                    if (r_settle_cnt == SETTLE_LAST) begin
                        w_state_nxt     = ST_ACQUIRE;
                        w_gap_nxt       = '0;
                        w_valid_cnt_nxt = '0;
                        w_sec_seen_nxt  = 1'b0;
                        w_armed_nxt     = 1'b0;
                    end else begin
                        w_settle_cnt_nxt = r_settle_cnt + 1'b1;
                    end
                end

                ST_ACQUIRE: begin
                    if (w_acq_fail) begin
                        w_retries_nxt = w_retries_inc;
                        if (auto_flip_i) begin
                            w_polarity_nxt = !r_polarity;
                        end
                        if (w_retries_inc == RETRY_MAX) begin
                            w_state_nxt       = ST_FAULT;
                            w_fault_nxt       = 1'b1;
                            w_recovery_en_nxt = 1'b0;
                        end else begin
                            w_state_nxt      = ST_SETTLE;
                            w_settle_cnt_nxt = '0;
                        end
                    end else if (primary_edge_i) begin
                        if (!r_armed) begin
                            w_armed_nxt = 1'b1;
                        end else begin
                            w_valid_cnt_nxt = r_valid_cnt + 1'b1;
                            if (r_valid_cnt == LOCK_LAST) begin
                                w_state_nxt  = ST_LOCKED;
                                w_locked_nxt = 1'b1;
                                w_period_nxt = w_period_val;
                            end
                        end
                    end
                end

                ST_LOCKED: begin
                    if (w_violation) begin
                        w_state_nxt      = ST_SETTLE;
                        w_locked_nxt     = 1'b0;
                        w_lost_nxt       = 1'b1;
                        w_retries_nxt    = '0;
                        w_settle_cnt_nxt = '0;
                    end else if (primary_edge_i) begin
                        w_period_nxt = w_period_val;
                    end
                end

                default: begin
                    // IDLE and FAULT wait for start_i or stop_i.
                end
            endcase
        end
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state       <= ST_IDLE;
            r_gap         <= '0;
            r_settle_cnt  <= '0;
            r_valid_cnt   <= '0;
            r_armed       <= 1'b0;
            r_sec_seen    <= 1'b0;
            r_recovery_en <= 1'b0;
            r_polarity    <= 1'b0;
            r_mode        <= clks_alot_p::recovery_mode_e'(2'd0);
            r_locked      <= 1'b0;
            r_lost        <= 1'b0;
            r_fault       <= 1'b0;
            r_period      <= '0;
            r_retries     <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values,
            // independent of statement order.
            r_state       <= w_state_nxt;
            r_gap         <= w_gap_nxt;
            r_settle_cnt  <= w_settle_cnt_nxt;
            r_valid_cnt   <= w_valid_cnt_nxt;
            r_armed       <= w_armed_nxt;
            r_sec_seen    <= w_sec_seen_nxt;
            r_recovery_en <= w_recovery_en_nxt;
            r_polarity    <= w_polarity_nxt;
            r_mode        <= w_mode_nxt;
            r_locked      <= w_locked_nxt;
            r_lost        <= w_lost_nxt;
            r_fault       <= w_fault_nxt;
            r_period      <= w_period_nxt;
            r_retries     <= w_retries_nxt;
        end
    end

    assign recovery_en_o     = r_recovery_en;
    assign polarity_select_o = r_polarity;
    assign recovery_mode_o   = r_mode;
    assign locked_o          = r_locked;
    assign lost_o            = r_lost;
    assign fault_o           = r_fault;
    assign period_o          = r_period;
    assign retries_o         = r_retries;

endmodule

// File: tb/tb_recovery_supervisor.sv
// Directed testbench for recovery_supervisor (default parameters).
module tb_recovery_supervisor;
    import clks_alot_p::*;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    common_p::clk_dom sys_dom;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    recovery_mode_e   cfg_mode = REC_MODE_EDGE;
    logic             cfg_polarity = 1'b0;
    logic             auto_flip = 1'b0;
    logic             check_secondary = 1'b0;
    logic [CNT_W-1:0] timeout = '0;
    logic             primary = 1'b0;
    logic             secondary = 1'b0;

    logic             en_o;
    logic             pol_o;
    recovery_mode_e   mode_o;
    logic             locked_o;
    logic             lost_o;
    logic             fault_o;
    logic [CNT_W-1:0] period_o;
    logic [3:0]       retries_o;

    int n_checks = 0;
    int n_fail   = 0;

    assign sys_dom.clk   = clk;
    assign sys_dom.rst_n = rst_n;

    always #5 clk = ~clk;

    recovery_supervisor dut (
        .sys_dom_i        (sys_dom),
        .start_i          (start),
        .stop_i           (stop),
        .cfg_mode_i       (cfg_mode),
        .cfg_polarity_i   (cfg_polarity),
        .auto_flip_i      (auto_flip),
        .check_secondary_i(check_secondary),
        .timeout_i        (timeout),
        .primary_edge_i   (primary),
        .secondary_edge_i (secondary),
        .recovery_en_o    (en_o),
        .polarity_select_o(pol_o),
        .recovery_mode_o  (mode_o),
        .locked_o         (locked_o),
        .lost_o           (lost_o),
        .fault_o          (fault_o),
        .period_o         (period_o),
        .retries_o        (retries_o)
    );

    // One clock: inputs set before this call are sampled at the edge,
    // outputs are observed 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic edge_pulse();
        primary = 1'b1;
        step();
        primary = 1'b0;
    endtask

    task automatic do_start(input logic pol, input recovery_mode_e mode);
        cfg_polarity = pol;
        cfg_mode     = mode;
        start        = 1'b1;
        step();
        start        = 1'b0;
    endtask

    // Called on ACQUIRE entry: one arming edge plus 8 valid intervals of 'period'.
    task automatic lock_seq(input int period, input string tag);
        for (int i = 1; i <= 9; i++) begin
            edge_pulse();
            if (i == 8) begin
                n_checks++;
                if (locked_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s_early_lock: locked_o=%0b expected 0", tag, locked_o);
                end
            end
            if (i < 9) idle(period - 1);
        end
        n_checks++;
        if (locked_o !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_lock: locked_o=%0b expected 1", tag, locked_o);
        end
        n_checks++;
        if (period_o !== CNT_W'(period)) begin
            n_fail++;
            $display("FAIL %s_period: period_o=%0d expected %0d", tag, period_o, period);
        end
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if ({en_o, pol_o, locked_o, lost_o, fault_o, retries_o, period_o, mode_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_values: en=%0b pol=%0b lock=%0b lost=%0b fault=%0b retries=%0d period=%0d mode=%0d expected all 0",
                     en_o, pol_o, locked_o, lost_o, fault_o, retries_o, period_o, mode_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            edge_pulse();
            idle(4);
        end
        n_checks++;
        if ({en_o, locked_o, fault_o, retries_o} !== '0) begin
            n_fail++;
            $display("FAIL idle_after_reset: en=%0b lock=%0b fault=%0b retries=%0d expected all 0",
                     en_o, locked_o, fault_o, retries_o);
        end
    endtask

    task automatic test_lock();
        timeout = 20;
        do_start(1'b1, REC_MODE_MANCHESTER);
        n_checks++;
        if (en_o !== 1'b1 || pol_o !== 1'b1 || mode_o !== REC_MODE_MANCHESTER) begin
            n_fail++;
            $display("FAIL start_outputs: en=%0b pol=%0b mode=%0d expected 1 1 %0d",
                     en_o, pol_o, mode_o, REC_MODE_MANCHESTER);
        end
        idle(4);
        lock_seq(10, "lock10");
    endtask

    task automatic test_loss_relock();
        idle(20);
        n_checks++;
        if (locked_o !== 1'b1 || lost_o !== 1'b0) begin
            n_fail++;
            $display("FAIL loss_early: locked=%0b lost=%0b expected 1 0", locked_o, lost_o);
        end
        step();
        n_checks++;
        if (lost_o !== 1'b1 || locked_o !== 1'b0 || en_o !== 1'b1 || pol_o !== 1'b1) begin
            n_fail++;
            $display("FAIL loss_pulse: lost=%0b locked=%0b en=%0b pol=%0b expected 1 0 1 1",
                     lost_o, locked_o, en_o, pol_o);
        end
        step();
        n_checks++;
        if (lost_o !== 1'b0) begin
            n_fail++;
            $display("FAIL loss_single_cycle: lost=%0b expected 0", lost_o);
        end
        idle(3);
        lock_seq(10, "relock");
    endtask

    task automatic test_stop_start();
        stop         = 1'b1;
        start        = 1'b1;
        cfg_polarity = 1'b0;
        step();
        stop  = 1'b0;
        start = 1'b0;
        n_checks++;
        if (en_o !== 1'b0 || locked_o !== 1'b0 || pol_o !== 1'b1 || period_o !== 16'd10
            || mode_o !== REC_MODE_MANCHESTER) begin
            n_fail++;
            $display("FAIL stop_wins: en=%0b lock=%0b pol=%0b period=%0d mode=%0d expected 0 0 1 10 %0d",
                     en_o, locked_o, pol_o, period_o, mode_o, REC_MODE_MANCHESTER);
        end
        for (int i = 0; i < 12; i++) begin
            edge_pulse();
            idle(9);
        end
        n_checks++;
        if (en_o !== 1'b0 || locked_o !== 1'b0 || lost_o !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ignores_events: en=%0b lock=%0b lost=%0b expected 0 0 0",
                     en_o, locked_o, lost_o);
        end
    endtask

    task automatic test_retry_fault();
        check_secondary = 1'b1;
        auto_flip       = 1'b1;
        do_start(1'b0, REC_MODE_EDGE);
        for (int f = 1; f <= 3; f++) begin
            idle(4);
            edge_pulse();
            idle(9);
            edge_pulse();
            n_checks++;
            if (retries_o !== 4'(f)) begin
                n_fail++;
                $display("FAIL retry_count_%0d: retries_o=%0d expected %0d", f, retries_o, f);
            end
            if (f < 3) begin
                n_checks++;
                if (pol_o !== f[0] || fault_o !== 1'b0 || en_o !== 1'b1) begin
                    n_fail++;
                    $display("FAIL retry_flip_%0d: pol=%0b fault=%0b en=%0b expected %0b 0 1",
                             f, pol_o, fault_o, en_o, f[0]);
                end
            end else begin
                n_checks++;
                if (fault_o !== 1'b1 || en_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL fault_entry: fault=%0b en=%0b expected 1 0", fault_o, en_o);
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            edge_pulse();
            idle(9);
        end
        n_checks++;
        if (fault_o !== 1'b1 || retries_o !== 4'd3 || en_o !== 1'b0) begin
            n_fail++;
            $display("FAIL fault_sticky: fault=%0b retries=%0d en=%0b expected 1 3 0",
                     fault_o, retries_o, en_o);
        end
        check_secondary = 1'b0;
        auto_flip       = 1'b0;
    endtask

    task automatic test_timeout_boundary();
        timeout = 20;
        do_start(1'b0, REC_MODE_PULSE);
        n_checks++;
        if (fault_o !== 1'b0 || retries_o !== 4'd0 || en_o !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_from_fault: fault=%0b retries=%0d en=%0b expected 0 0 1",
                     fault_o, retries_o, en_o);
        end
        idle(4);
        lock_seq(20, "interval20");
        n_checks++;
        if (retries_o !== 4'd0) begin
            n_fail++;
            $display("FAIL interval20_retries: retries_o=%0d expected 0", retries_o);
        end
        do_start(1'b0, REC_MODE_PULSE);
        n_checks++;
        if (locked_o !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_clears_lock: locked_o=%0b expected 0", locked_o);
        end
        idle(4);
        edge_pulse();
        idle(20);
        n_checks++;
        if (retries_o !== 4'd0) begin
            n_fail++;
            $display("FAIL interval21_early: retries_o=%0d expected 0", retries_o);
        end
        edge_pulse();
        n_checks++;
        if (retries_o !== 4'd1 || locked_o !== 1'b0) begin
            n_fail++;
            $display("FAIL interval21_reject: retries=%0d locked=%0b expected 1 0", retries_o, locked_o);
        end
    endtask

    task automatic test_timeout_disabled();
        timeout = 0;
        do_start(1'b1, REC_MODE_BIPHASE);
        idle(4);
        edge_pulse();
        idle(4999);
        edge_pulse();
        n_checks++;
        if (retries_o !== 4'd0 || locked_o !== 1'b0) begin
            n_fail++;
            $display("FAIL interval5000_accept: retries=%0d locked=%0b expected 0 0", retries_o, locked_o);
        end
        for (int i = 0; i < 7; i++) begin
            idle(9);
            edge_pulse();
        end
        n_checks++;
        if (locked_o !== 1'b1 || period_o !== 16'd10) begin
            n_fail++;
            $display("FAIL nolimit_lock: locked=%0b period=%0d expected 1 10", locked_o, period_o);
        end
    endtask

    task automatic test_async_reset_locked();
        idle(3);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({en_o, pol_o, locked_o, lost_o, fault_o, retries_o, period_o, mode_o} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: en=%0b pol=%0b lock=%0b lost=%0b fault=%0b retries=%0d period=%0d mode=%0d expected all 0",
                     en_o, pol_o, locked_o, lost_o, fault_o, retries_o, period_o, mode_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            edge_pulse();
            idle(9);
        end
        n_checks++;
        if ({en_o, pol_o, locked_o, lost_o, fault_o, retries_o, period_o, mode_o} !== '0) begin
            n_fail++;
            $display("FAIL post_reset_idle: en=%0b lock=%0b retries=%0d period=%0d expected all 0",
                     en_o, locked_o, retries_o, period_o);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_loss_relock();
        test_stop_start();
        test_retry_fault();
        test_timeout_boundary();
        test_timeout_disabled();
        test_async_reset_locked();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
